// File: rtl/uart_reg_arbiter.sv
// uart_reg_arbiter: shares one UART register port between two requesters.
// Runs a six-write init sequence after reset or reinit. It then grants
// accesses round-robin through a four-cycle SETUP/STROBE/CAPTURE/gap engine.
module uart_reg_arbiter #(
    parameter logic [15:0] DIVISOR = 16'h0011,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'h00,
    parameter logic [7:0]  IER_VAL = 8'h03
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    input  logic       r0_req,
    input  logic       r0_wr,
    input  logic [2:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_gnt,
    output logic       r0_done,
    output logic [7:0] r0_rdata,
    input  logic       r1_req,
    input  logic       r1_wr,
    input  logic [2:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_gnt,
    output logic       r1_done,
    output logic [7:0] r1_rdata,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic [2:0] a,
    output logic [7:0] din,
    input  logic [7:0] dout,
    output logic       init_done
);

    typedef enum logic [2:0] {INIT_IDLE, IDLE, SETUP, STROBE, CAPTURE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      step, step_nxt;
    logic            init_done_nxt;
    logic            pend, pend_nxt;       // reinit seen mid-access, honoured in next IDLE
    logic            ptr, ptr_nxt;         // 0: r0 has priority on a tie
    logic            owner, owner_nxt;
    logic            acc_wr, acc_wr_nxt;
    logic            cs_nxt, wr_nxt, rd_nxt;
    logic [2:0]      a_nxt;
    logic [7:0]      din_nxt;
    logic [1:0]      gnt, gnt_nxt;
    logic [1:0]      done, done_nxt;
    logic [1:0][7:0] rdata, rdata_nxt;
    logic [1:0]      elig;
    logic            win;
    logic [2:0]      init_a;
    logic [7:0]      init_d;

    // The requester finishing this cycle still holds req; mask it so the other side gets a turn.
    assign elig = {r1_req, r0_req} & ~done;
    assign win  = (elig == 2'b11) ? ptr : elig[1];

    assign r0_gnt   = gnt[0];
    assign r1_gnt   = gnt[1];
    assign r0_done  = done[0];
    assign r1_done  = done[1];
    assign r0_rdata = rdata[0];
    assign r1_rdata = rdata[1];

    // Init write table: register address and data for each step.
    always_comb begin
        init_a = 3'd0;
        init_d = 8'h00;
        case (step)
            3'd0: begin init_a = 3'd3; init_d = LCR_VAL | 8'h80; end
            3'd1: begin init_a = 3'd0; init_d = DIVISOR[7:0];    end
            3'd2: begin init_a = 3'd1; init_d = DIVISOR[15:8];   end
            3'd3: begin init_a = 3'd3; init_d = LCR_VAL;         end
            3'd4: begin init_a = 3'd2; init_d = FCR_VAL;         end
            3'd5: begin init_a = 3'd1; init_d = IER_VAL;         end
            default: ;
        endcase
    end

    // Next-state, arbitration and registered bus strobes.
    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        init_done_nxt = init_done;
        pend_nxt      = pend;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        acc_wr_nxt    = acc_wr;
        a_nxt         = a;
        din_nxt       = din;
        rdata_nxt     = rdata;
        cs_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        rd_nxt        = 1'b0;
        gnt_nxt       = 2'b00;
        done_nxt      = 2'b00;

        // reinit during init is dropped; during a normal access it is deferred.
        if (init_done && reinit && state != IDLE)
            pend_nxt = 1'b1;

        case (state)
            INIT_IDLE: begin
                state_nxt  = SETUP;
                cs_nxt     = 1'b1;
                acc_wr_nxt = 1'b1;
                a_nxt      = init_a;
                din_nxt    = init_d;
            end
            IDLE: begin
                if (reinit || pend) begin
                    init_done_nxt = 1'b0;
                    step_nxt      = 3'd0;
                    pend_nxt      = 1'b0;
                    state_nxt     = INIT_IDLE;
                end else if (init_done && elig != 2'b00) begin
                    state_nxt    = SETUP;
                    cs_nxt       = 1'b1;
                    owner_nxt    = win;
                    ptr_nxt      = ~win;
                    gnt_nxt[win] = 1'b1;
                    acc_wr_nxt   = win ? r1_wr    : r0_wr;
                    a_nxt        = win ? r1_addr  : r0_addr;
                    din_nxt      = win ? r1_wdata : r0_wdata;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                cs_nxt    = 1'b1;
                wr_nxt    = acc_wr;
                rd_nxt    = ~acc_wr;
            end
            STROBE: begin
                state_nxt = CAPTURE;
                cs_nxt    = 1'b1;
            end
            CAPTURE: begin
                if (!init_done) begin
                    if (step == 3'd5) begin
                        init_done_nxt = 1'b1;
                        step_nxt      = 3'd0;
                        state_nxt     = IDLE;
                    end else begin
                        step_nxt  = step + 3'd1;
                        state_nxt = INIT_IDLE;
                    end
                end else begin
                    state_nxt       = IDLE;
                    done_nxt[owner] = 1'b1;
                    if (!acc_wr)
                        rdata_nxt[owner] = dout;
                end
            end
            default: begin
                state_nxt = INIT_IDLE;
                step_nxt  = 3'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_IDLE;
            step      <= 3'd0;
            init_done <= 1'b0;
            pend      <= 1'b0;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            acc_wr    <= 1'b0;
            cs        <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            a         <= 3'd0;
            din       <= 8'h00;
            gnt       <= 2'b00;
            done      <= 2'b00;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            init_done <= init_done_nxt;
            pend      <= pend_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            acc_wr    <= acc_wr_nxt;
            cs        <= cs_nxt;
            wr        <= wr_nxt;
            rd        <= rd_nxt;
            a         <= a_nxt;
            din       <= din_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Bench for uart_reg_arbiter: directed scenarios plus a randomized two-requester
// run checked against a transaction-level timing/arbitration model.
module tb_uart_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic       r0_req = 1'b0, r0_wr = 1'b0;
    logic [2:0] r0_addr = 3'd0;
    logic [7:0] r0_wdata = 8'h00;
    logic       r0_gnt, r0_done;
    logic [7:0] r0_rdata;
    logic       r1_req = 1'b0, r1_wr = 1'b0;
    logic [2:0] r1_addr = 3'd0;
    logic [7:0] r1_wdata = 8'h00;
    logic       r1_gnt, r1_done;
    logic [7:0] r1_rdata;
    logic       cs, wr, rd;
    logic [2:0] a;
    logic [7:0] din;
    logic [7:0] dout = 8'h00;
    logic       init_done;

    int vec  = 0;
    int errs = 0;

    // Expected init writes for default parameters (LCR|80, DLL, DLM, LCR, FCR, IER).
    logic [2:0] tbl_a [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    logic [7:0] tbl_d [6] = '{8'h83, 8'h11, 8'h00, 8'h03, 8'h00, 8'h03};

    uart_reg_arbiter dut (
        .clk(clk), .rst(rst), .reinit(reinit),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .cs(cs), .wr(wr), .rd(rd), .a(a), .din(din), .dout(dout),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vec++; if ({cs, wr, rd} !== 3'b000) begin errs++; $display("FAIL reset_strobes got %b want 000", {cs, wr, rd}); end
        vec++; if ({a, din} !== 11'h0) begin errs++; $display("FAIL reset_bus got a=%h din=%h want 0/00", a, din); end
        vec++; if ({r0_gnt, r1_gnt, r0_done, r1_done} !== 4'b0) begin errs++; $display("FAIL reset_handshake got %b want 0000", {r0_gnt, r1_gnt, r0_done, r1_done}); end
        vec++; if ({r0_rdata, r1_rdata} !== 16'h0) begin errs++; $display("FAIL reset_rdata got %h/%h want 00/00", r0_rdata, r1_rdata); end
        vec++; if (init_done !== 1'b0) begin errs++; $display("FAIL reset_init_done got %b want 0", init_done); end
    endtask

    // Releases rst (if held) and checks the six init writes and the 24th-edge init_done.
    task automatic test_init(input string tag);
        logic [2:0] wa[$];
        logic [7:0] wd[$];
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (wr === 1'b1) begin wa.push_back(a); wd.push_back(din); end
            vec++;
            if (rd !== 1'b0 || (wr === 1'b1 && cs !== 1'b1) || {r0_gnt, r1_gnt, r0_done, r1_done} !== 4'b0) begin
                errs++; $display("FAIL %s init_bus_legal edge%0d got cs/wr/rd=%b%b%b hs=%b want no rd/handshake", tag, k, cs, wr, rd, {r0_gnt, r1_gnt, r0_done, r1_done});
            end
            if (k >= 23) begin
                vec++;
                if (init_done !== (k == 24)) begin errs++; $display("FAIL %s init_done_edge%0d got %b want %b", tag, k, init_done, (k == 24)); end
            end
        end
        vec++;
        if (wa.size() != 6) begin
            errs++; $display("FAIL %s init_write_count got %0d want 6", tag, wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vec++;
                if (wa[i] !== tbl_a[i] || wd[i] !== tbl_d[i]) begin
                    errs++; $display("FAIL %s init_write%0d got %h/%h want %h/%h", tag, i, wa[i], wd[i], tbl_a[i], tbl_d[i]);
                end
            end
        end
    endtask

    // Drops each request at its done until both are idle.
    task automatic drain();
        for (int i = 0; i < 40 && (r0_req || r1_req); i++) begin
            tick();
            if (r0_done) r0_req = 1'b0;
            if (r1_done) r1_req = 1'b0;
        end
        vec++;
        if (r0_req || r1_req) begin errs++; $display("FAIL drain_timeout got req=%b%b want 00", r1_req, r0_req); end
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
    endtask

    task automatic test_alternate();
        int who[$];
        int when[$];
        r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 3'd1; r0_wdata = 8'hAA;
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 3'd2;
        for (int k = 1; k <= 30; k++) begin
            tick();
            vec++;
            if (r0_gnt && r1_gnt) begin errs++; $display("FAIL alt_double_grant cycle%0d got both want one", k); end
            if (r0_gnt) begin who.push_back(0); when.push_back(k); end
            if (r1_gnt) begin who.push_back(1); when.push_back(k); end
        end
        vec++;
        if (who.size() < 4) begin
            errs++; $display("FAIL alt_grant_count got %0d want >=4", who.size());
        end else begin
            for (int i = 0; i < who.size(); i++) begin
                vec++;
                if (who[i] != (i % 2) || when[i] != 1 + 4 * i) begin
                    errs++; $display("FAIL alt_grant%0d got r%0d@%0d want r%0d@%0d", i, who[i], when[i], i % 2, 1 + 4 * i);
                end
            end
        end
        drain();
    endtask

    task automatic test_single_read();
        int gk = -1, dk = -1, rdn = 0, csn = 0;
        logic [7:0] rv = 8'h00;
        logic [2:0] ra = 3'd0;
        dout = 8'h60;
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 3'd5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (r0_gnt && gk < 0) gk = k;
            if (r0_done && dk < 0) begin dk = k; rv = r0_rdata; r0_req = 1'b0; end
            if (rd) begin rdn++; ra = a; end
            if (cs) csn++;
        end
        vec++; if (gk != 1) begin errs++; $display("FAIL read_gnt_cycle got %0d want 1", gk); end
        vec++; if (dk != 4) begin errs++; $display("FAIL read_done_cycle got %0d want 4", dk); end
        vec++; if (rv !== 8'h60) begin errs++; $display("FAIL read_rdata got %h want 60", rv); end
        vec++; if (rdn != 1) begin errs++; $display("FAIL read_rd_cycles got %0d want 1", rdn); end
        vec++; if (ra !== 3'd5) begin errs++; $display("FAIL read_addr got %0d want 5", ra); end
        vec++; if (csn != 3) begin errs++; $display("FAIL read_cs_cycles got %0d want 3", csn); end
    endtask

    task automatic test_reinit_busy();
        int r1d = -1, fall = -1, rise = -1, g0 = -1, d0 = -1;
        logic [7:0] rv0 = 8'h00;
        logic [2:0] wa[$];
        logic [7:0] wd[$];
        dout = 8'hC3;
        r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 3'd4; r1_wdata = 8'h5A;
        tick();
        vec++; if (r1_gnt !== 1'b1) begin errs++; $display("FAIL rb_r1_gnt got %b want 1", r1_gnt); end
        reinit = 1'b1;
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 3'd6;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 1) reinit = 1'b0;
            if (wr) begin wa.push_back(a); wd.push_back(din); end
            if (r1_done && r1d < 0) begin r1d = k; r1_req = 1'b0; end
            if (!init_done && fall < 0) fall = k;
            if (init_done && fall >= 0 && rise < 0) rise = k;
            if (r0_gnt && g0 < 0) g0 = k;
            if (r0_done && d0 < 0) begin d0 = k; rv0 = r0_rdata; r0_req = 1'b0; end
        end
        vec++; if (r1d != 3)  begin errs++; $display("FAIL rb_r1_done got %0d want 3", r1d); end
        vec++; if (fall != 4) begin errs++; $display("FAIL rb_init_fall got %0d want 4", fall); end
        vec++; if (rise != 28) begin errs++; $display("FAIL rb_init_rise got %0d want 28", rise); end
        vec++; if (g0 != 29)  begin errs++; $display("FAIL rb_r0_gnt got %0d want 29", g0); end
        vec++; if (d0 != 32 || rv0 !== 8'hC3) begin errs++; $display("FAIL rb_r0_done got %0d/%h want 32/c3", d0, rv0); end
        vec++;
        if (wa.size() != 7) begin
            errs++; $display("FAIL rb_write_count got %0d want 7", wa.size());
        end else begin
            vec++; if (wa[0] !== 3'd4 || wd[0] !== 8'h5A) begin errs++; $display("FAIL rb_r1_write got %h/%h want 4/5a", wa[0], wd[0]); end
            for (int i = 0; i < 6; i++) begin
                vec++;
                if (wa[i+1] !== tbl_a[i] || wd[i+1] !== tbl_d[i]) begin
                    errs++; $display("FAIL rb_init_write%0d got %h/%h want %h/%h", i, wa[i+1], wd[i+1], tbl_a[i], tbl_d[i]);
                end
            end
        end
    endtask

    task automatic test_reinit_idle();
        int nw = 0;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        vec++; if (init_done !== 1'b0) begin errs++; $display("FAIL ri_clear got %b want 0", init_done); end
        for (int k = 2; k <= 27; k++) begin
            tick();
            if (k == 6) reinit = 1'b1;
            if (k == 7) reinit = 1'b0;
            if (wr) begin
                vec++;
                if (nw < 6 && (a !== tbl_a[nw] || din !== tbl_d[nw])) begin
                    errs++; $display("FAIL ri_write%0d got %h/%h want %h/%h", nw, a, din, tbl_a[nw], tbl_d[nw]);
                end
                nw++;
            end
            if (k == 24) begin vec++; if (init_done !== 1'b0) begin errs++; $display("FAIL ri_done_edge24 got %b want 0", init_done); end end
            if (k == 25 || k == 27) begin vec++; if (init_done !== 1'b1) begin errs++; $display("FAIL ri_done_edge%0d got %b want 1", k, init_done); end end
        end
        vec++; if (nw != 6) begin errs++; $display("FAIL ri_write_count got %0d want 6", nw); end
    endtask

    task automatic test_rst_mid();
        r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 3'd7; r0_wdata = 8'h99;
        tick();
        vec++; if (r0_gnt !== 1'b1) begin errs++; $display("FAIL rm_gnt got %b want 1", r0_gnt); end
        tick();
        vec++; if (wr !== 1'b1) begin errs++; $display("FAIL rm_strobe got %b want 1", wr); end
        rst = 1'b1;
        tick();
        vec++; if ({cs, wr, rd} !== 3'b000) begin errs++; $display("FAIL rm_abort_strobes got %b want 000", {cs, wr, rd}); end
        vec++; if ({r0_done, init_done, a} !== 5'b0) begin errs++; $display("FAIL rm_abort_state got done=%b init=%b a=%h want 0/0/0", r0_done, init_done, a); end
        r0_req = 1'b0;
        tick();
        vec++; if (r0_done !== 1'b0) begin errs++; $display("FAIL rm_no_done got %b want 0", r0_done); end
        test_init("rst_restart");
    endtask

    // Randomized traffic; model predicts grant edges, done timing, bus content and rdata.
    task automatic test_random();
        logic       req_m[2], wr_m[2], busy_m[2];
        logic [2:0] ad_m[2];
        logic [7:0] wd_m[2], rd_m[2];
        int g_last = -100, own = 0, last_win = 1, pw = -1;
        logic p_wr = 1'b0, acc_wr = 1'b0;
        logic [2:0] p_ad = 3'd0, acc_ad = 3'd0;
        logic [7:0] p_wd = 8'h00, acc_wd = 8'h00, cap_val = 8'h00;
        logic [1:0] exp_g, exp_d;
        logic [2:0] exp_s;
        logic e0, e1;
        for (int n = 0; n < 2; n++) begin
            req_m[n] = 1'b0; wr_m[n] = 1'b0; busy_m[n] = 1'b0;
            ad_m[n] = 3'd0; wd_m[n] = 8'h00; rd_m[n] = 8'h00;
        end
        for (int c = 1; c <= 700; c++) begin
            tick();
            exp_g = 2'b00;
            if (pw >= 0) begin
                g_last = c; own = pw; acc_wr = p_wr; acc_ad = p_ad; acc_wd = p_wd;
                busy_m[own] = 1'b1; exp_g[own] = 1'b1;
            end
            exp_d = 2'b00;
            if (c == g_last + 3) begin
                exp_d[own] = 1'b1;
                if (!acc_wr) rd_m[own] = cap_val;
            end
            exp_s = {(c >= g_last && c <= g_last + 2), (c == g_last + 1) && acc_wr, (c == g_last + 1) && !acc_wr};
            vec++; if ({r1_gnt, r0_gnt} !== exp_g) begin errs++; $display("FAIL rnd_gnt c%0d got %b want %b", c, {r1_gnt, r0_gnt}, exp_g); end
            vec++; if ({r1_done, r0_done} !== exp_d) begin errs++; $display("FAIL rnd_done c%0d got %b want %b", c, {r1_done, r0_done}, exp_d); end
            vec++; if ({cs, wr, rd} !== exp_s) begin errs++; $display("FAIL rnd_strobes c%0d got %b want %b", c, {cs, wr, rd}, exp_s); end
            vec++; if (r0_rdata !== rd_m[0] || r1_rdata !== rd_m[1]) begin errs++; $display("FAIL rnd_rdata c%0d got %h/%h want %h/%h", c, r0_rdata, r1_rdata, rd_m[0], rd_m[1]); end
            if (c >= g_last && c <= g_last + 2) begin
                vec++;
                if (a !== acc_ad || (acc_wr && din !== acc_wd)) begin
                    errs++; $display("FAIL rnd_bus c%0d got %h/%h want %h/%h", c, a, din, acc_ad, acc_wd);
                end
            end
            if (c == g_last + 3) begin req_m[own] = 1'b0; busy_m[own] = 1'b0; end
            dout = 8'($urandom);
            if (c == g_last + 2) cap_val = dout;
            for (int n = 0; n < 2; n++) begin
                if (busy_m[n] || (!req_m[n] && $urandom_range(0, 2) == 0)) begin
                    if (!busy_m[n]) req_m[n] = 1'b1;
                    wr_m[n] = 1'($urandom_range(0, 1));
                    ad_m[n] = 3'($urandom);
                    wd_m[n] = 8'($urandom);
                end
            end
            r0_req = req_m[0]; r0_wr = wr_m[0]; r0_addr = ad_m[0]; r0_wdata = wd_m[0];
            r1_req = req_m[1]; r1_wr = wr_m[1]; r1_addr = ad_m[1]; r1_wdata = wd_m[1];
            e0 = req_m[0] && !busy_m[0] && !(c == g_last + 3 && own == 0);
            e1 = req_m[1] && !busy_m[1] && !(c == g_last + 3 && own == 1);
            pw = -1;
            if (c >= g_last + 3 && (e0 || e1)) begin
                pw = (e0 && e1) ? (last_win == 0 ? 1 : 0) : (e0 ? 0 : 1);
                last_win = pw;
                p_wr = wr_m[pw]; p_ad = ad_m[pw]; p_wd = wd_m[pw];
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_init("por");
        test_alternate();
        test_single_read();
        test_reinit_busy();
        test_reinit_idle();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/uart_reg_arbiter.md
UART_REG_ARBITER -- requirements
Module: uart_reg_arbiter

Interface
REQ-001 Parameter DIVISOR, default 16'h0011: baud divisor written to DLL (low byte) and DLM (high byte) during init.
REQ-002 Parameter LCR_VAL, default 8'h03: final line control value (8N1).
REQ-003 Parameter FCR_VAL, default 8'h00: FIFO control value.
REQ-004 Parameter IER_VAL, default 8'h03: interrupt enable value.
REQ-005 clk  in  1  single block clock; every register updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 reinit  in  1  one-cycle pulse; re-runs the init sequence.
REQ-008 rN_req  in  1  (N=0,1) access request; held high until rN_done.
REQ-009 rN_wr  in  1  1 = register write, 0 = register read.
REQ-010 rN_addr  in  3  UART register address.
REQ-011 rN_wdata  in  8  write data.
REQ-012 rN_gnt  out  1  one-cycle pulse: request accepted.
REQ-013 rN_done  out  1  one-cycle pulse: access complete; rN_rdata valid.
REQ-014 rN_rdata  out  8  read data; holds until the next read by the same requester.
REQ-015 cs, wr, rd  out  1 each  registered UART strobes.
REQ-016 a  out  3  registered UART address.
REQ-017 din  out  8  registered UART write data.
REQ-018 dout  in  8  UART read data.
REQ-019 init_done  out  1  high once the init sequence completes; requests are granted only while it is high.

Function
REQ-020 Every access SHALL use a four-cycle engine: SETUP (cs=1, a/din valid, wr=rd=0); STROBE (cs=1, wr or rd=1); CAPTURE (cs=1, wr=rd=0); gap (cs=0).
REQ-021 On the edge leaving CAPTURE, the engine SHALL return to IDLE and pulse the owner's done; for a read it SHALL also load dout into the owner's rdata.
REQ-022 Arbitration SHALL occur in IDLE only; on the deciding edge the state SHALL go to SETUP, the winner's wr/addr/wdata SHALL be latched, and the winner's gnt SHALL pulse.
REQ-023 Latency from a granted request to done SHALL be 3 cycles; back-to-back accesses SHALL be 4 cycles apart.
REQ-024 In a done cycle, the requester just served SHALL be masked from arbitration.
REQ-025 Arbitration SHALL be round-robin: the priority pointer moves to the other requester after each grant; the reset value is r0.
REQ-026 If only one requester is active, it SHALL win regardless of the pointer.
REQ-027 rN_req input changes after gnt SHALL NOT alter an access in progress.
REQ-028 Init sequence, six writes in order: LCR=LCR_VAL|8'h80, DLL=DIVISOR[7:0], DLM=DIVISOR[15:8], LCR=LCR_VAL, FCR=FCR_VAL, IER=IER_VAL.
REQ-029 The init sequence SHALL start on the first edge after rst deasserts; init_done SHALL rise on the 24th edge.
REQ-030 State machine states: INIT_IDLE, IDLE, SETUP, STROBE, CAPTURE, plus a 3-bit init step counter.
REQ-031 While init runs, no gnt SHALL be issued and pending requests SHALL wait.
REQ-032 A reinit seen in IDLE SHALL clear init_done on the next edge and restart the six writes.
REQ-033 A reinit seen mid-access SHALL be held pending and honoured in the following IDLE; that access SHALL complete normally.
REQ-034 A reinit during init SHALL be ignored.
REQ-035 If reinit and a request arrive in the same IDLE cycle, reinit SHALL win and the request SHALL wait.
REQ-036 cs, wr and rd SHALL never be high outside an access; wr and rd SHALL never be high together.

Reset
REQ-037 While rst is high, the following SHALL be 0: cs, wr, rd, a, din, all gnt/done, all rdata, init_done, the pending-reinit flag and the init counter; the priority pointer SHALL be r0.
REQ-038 A rst asserted mid-access SHALL abort it: strobes SHALL drop on that edge and no done SHALL be issued.

Verification
REQ-039 Release rst -> six write accesses with a/din = 3/83, 0/11, 1/00, 3/03, 2/00, 1/03; init_done rises on the 24th edge.
REQ-040 r0 read of addr 5 with dout=8'h60 -> r0_gnt, then r0_done 3 cycles later with r0_rdata=8'h60; rd high exactly 1 cycle.
REQ-041 r0 and r1 both requesting continuously -> grants alternate r0,r1,r0,r1, 4 cycles apart.
REQ-042 reinit pulsed during an r1 write -> that write completes, init_done drops, six init writes follow, r0 request waits until init_done.
REQ-043 rst asserted during STROBE -> cs=wr=rd=0 on that edge, no done; the init sequence restarts after release.
